ahb_timer_mc: RTL

Multi-channel AHB-Lite timer: NCH independent up-counters, each with its own prescaler, compare value, one-shot/periodic mode and interrupt. It is the parametrised successor of the single-channel peripheral timer and sits on the peripheral AHB bus as a zero-wait-state slave. Per-channel and aggregated interrupt lines go to the interrupt controller.

---
 rtl/ahb_timer_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_timer_mc.sv
// Multi-channel AHB-Lite timer: NCH prescaled up-counters with compare, one-shot or
// periodic expiry and per-channel interrupts, served as a zero-wait-state slave.

module ahb_timer_mc #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int NCH    = 4,
  parameter int CWIDTH = 32,
  parameter int PWIDTH = 8
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [1:0]        htrans_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  input  logic [AWIDTH-1:0] haddr_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  output logic [NCH-1:0]    irq_o,
  output logic              irq_any_o
);

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_COUNT = 2'd1,
    REG_VALUE = 2'd2,
    REG_PRESC = 2'd3
  } reg_e;

  localparam logic [7:0] ADDR_STATUS = 8'h80;
  localparam logic [7:0] ADDR_START  = 8'h84;

  logic              accept;
  logic              dp_valid;
  logic              dp_write;
  logic              dp_word;
  logic [7:0]        dp_addr;

  logic [2:0]        ch_idx;
  reg_e              reg_sel;
  logic              is_chan;
  logic              sel_status;
  logic              sel_start;
  logic              wr;
  logic [DWIDTH-1:0] rdata;

  logic [NCH-1:0]    en_v;
  logic [NCH-1:0]    ie_v;
  logic [NCH-1:0]    pend_v;
  logic [NCH-1:0]    mode_v;
  logic [CWIDTH-1:0] count_v [NCH];
  logic [CWIDTH-1:0] value_v [NCH];
  logic [PWIDTH-1:0] presc_v [NCH];

  logic              unused_ok;

  assign accept = hsel_i & hready_i & htrans_i[1];

  // Address phase is captured here; the access itself completes in the following cycle.
  always_ff @(posedge hclk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_addr  <= haddr_i[7:0];
        dp_write <= hwrite_i;
        dp_word  <= (hsize_i == 3'b010);
      end
    end
  end

  assign ch_idx     = dp_addr[6:4];
  assign reg_sel    = reg_e'(dp_addr[3:2]);
  assign is_chan    = ~dp_addr[7] && (dp_addr[1:0] == 2'b00) && ({1'b0, ch_idx} < 4'(NCH));
  assign sel_status = (dp_addr == ADDR_STATUS);
  assign sel_start  = (dp_addr == ADDR_START);
  assign wr         = dp_valid & dp_write & dp_word;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic              en_r, ie_r, pend_r, mode_r;
    logic              en_d, ie_d, pend_d, mode_d;
    logic [CWIDTH-1:0] cnt_r, val_r, cnt_d, val_d;
    logic [PWIDTH-1:0] psc_r, pcnt_r, psc_d, pcnt_d;
    logic              hit, tick, expire, w1c, start;

    assign hit    = wr & is_chan & (ch_idx == 3'(n));
    assign tick   = en_r & (pcnt_r == psc_r);
    assign expire = tick & (cnt_r >= val_r);
    assign w1c    = hit & (reg_sel == REG_CTRL) & hwdata_i[2];
    assign start  = wr & sel_start & hwdata_i[n];

    // Hardware expiry is applied first so that a software CTRL write or START can override en.
    always_comb begin
      en_d   = en_r;
      ie_d   = ie_r;
      mode_d = mode_r;
      val_d  = val_r;
      psc_d  = psc_r;
      cnt_d  = cnt_r;
      pcnt_d = pcnt_r;
      if (en_r) begin
        if (tick) begin
          pcnt_d = '0;
          if (expire) begin
            cnt_d = '0;
            if (!mode_r) en_d = 1'b0;
          end else begin
            cnt_d = cnt_r + CWIDTH'(1);
          end
        end else begin
          pcnt_d = pcnt_r + PWIDTH'(1);
        end
      end
      if (hit && reg_sel == REG_CTRL) begin
        en_d   = hwdata_i[0];
        ie_d   = hwdata_i[1];
        mode_d = hwdata_i[3];
      end
      if (hit && reg_sel == REG_VALUE) val_d = hwdata_i[CWIDTH-1:0];
      if (hit && reg_sel == REG_PRESC) begin
        psc_d  = hwdata_i[PWIDTH-1:0];
        pcnt_d = '0;
      end
      if (start) en_d = 1'b1;
      if (!en_d) begin
        cnt_d  = '0;
        pcnt_d = '0;
      end
    end

    // An expiry in the same cycle as a W1C keeps the pending flag set.
    assign pend_d = expire | (pend_r & ~w1c);

    always_ff @(posedge hclk) begin
      if (rst) begin
        en_r   <= 1'b0;
        ie_r   <= 1'b0;
        pend_r <= 1'b0;
        mode_r <= 1'b0;
        cnt_r  <= '0;
        val_r  <= '0;
        psc_r  <= '0;
        pcnt_r <= '0;
      end else begin
        en_r   <= en_d;
        ie_r   <= ie_d;
        pend_r <= pend_d;
        mode_r <= mode_d;
        cnt_r  <= cnt_d;
        val_r  <= val_d;
        psc_r  <= psc_d;
        pcnt_r <= pcnt_d;
      end
    end

    assign en_v[n]    = en_r;
    assign ie_v[n]    = ie_r;
    assign pend_v[n]  = pend_r;
    assign mode_v[n]  = mode_r;
    assign count_v[n] = cnt_r;
    assign value_v[n] = val_r;
    assign presc_v[n] = psc_r;
  end

  always_comb begin
    rdata = '0;
    if (dp_valid && !dp_write) begin
      if (is_chan) begin
        for (int n = 0; n < NCH; n++) begin
          if (ch_idx == 3'(n)) begin
            case (reg_sel)
              REG_CTRL:  rdata[3:0]        = {mode_v[n], pend_v[n], ie_v[n], en_v[n]};
              REG_COUNT: rdata[CWIDTH-1:0] = count_v[n];
              REG_VALUE: rdata[CWIDTH-1:0] = value_v[n];
              REG_PRESC: rdata[PWIDTH-1:0] = presc_v[n];
              default:   rdata             = '0;
            endcase
          end
        end
      end else if (sel_status) begin
        rdata[NCH-1:0] = pend_v;
      end
    end
  end

  assign hrdata_o    = rdata;
  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;
  assign irq_o       = pend_v & ie_v;
  assign irq_any_o   = |(pend_v & ie_v);

  assign unused_ok = ^{hburst_i, haddr_i[AWIDTH-1:8], hwdata_i};

endmodule
